// File: rtl/gol_pkg.sv
// rtl/gol_pkg.sv - shared widths and enums for the GoL memory scheduler
package gol_pkg;

  localparam int ADDR_W_DFLT = 9;
  localparam int DATA_W_DFLT = 32;

  typedef enum logic [1:0] {
    START = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    IDLE  = 2'd3
  } gol_state_e;

  typedef enum logic {
    OWN_VID = 1'b0,
    OWN_ENG = 1'b1
  } gol_owner_e;

endpackage

// File: rtl/gol_mem_scheduler_if.sv
// rtl/gol_mem_scheduler_if.sv - single-port pixel memory bus between scheduler and memory macro
interface gol_mem_scheduler_if
  import gol_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT
);

  logic              en;
  logic              we;
  logic              bank;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (
    output en, we, bank, addr, wdata,
    input  rdata
  );

  modport slave (
    input  en, we, bank, addr, wdata,
    output rdata
  );

endinterface

// File: rtl/gol_mem_prio.sv
// rtl/gol_mem_prio.sv - combinational vid > eng > cfg priority pick and memory request mux
module gol_mem_prio
  import gol_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic              vid_ok,
  input  logic              eng_ok,
  input  logic              cfg_ok,
  input  logic              disp_bank,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic              eng_req,
  input  logic              eng_we,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [DATA_W-1:0] eng_wdata,
  input  logic              cfg_req,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic              eng_gnt,
  output logic              cfg_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_bank,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              rd_issue,
  output gol_owner_e        rd_owner
);

  always_comb begin
    eng_gnt   = 1'b0;
    cfg_gnt   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_bank  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rd_issue  = 1'b0;
    rd_owner  = OWN_VID;
    if (vid_req && vid_ok) begin
      mem_en   = 1'b1;
      mem_bank = disp_bank;
      mem_addr = vid_addr;
      rd_issue = 1'b1;
    end else if (eng_req && eng_ok) begin
      // engine reads the shown bank and builds the next generation in the hidden one
      eng_gnt   = 1'b1;
      mem_en    = 1'b1;
      mem_we    = eng_we;
      mem_bank  = eng_we ? ~disp_bank : disp_bank;
      mem_addr  = eng_addr;
      mem_wdata = eng_we ? eng_wdata : '0;
      rd_issue  = ~eng_we;
      rd_owner  = OWN_ENG;
    end else if (cfg_req && cfg_ok) begin
      cfg_gnt   = 1'b1;
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_bank  = ~disp_bank;
      mem_addr  = cfg_addr;
      mem_wdata = cfg_wdata;
    end
  end

endmodule

// File: rtl/gol_mem_scheduler.sv
// rtl/gol_mem_scheduler.sv - GoL double-buffer bank scheduler and memory arbiter
// Optional freeze input and IDLE hold state enabled by GOL_FREEZE_EN.
module gol_mem_scheduler
  import gol_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic                clk,
  input  logic                reset,
`ifdef GOL_FREEZE_EN
  input  logic                freeze,
`endif
  input  logic                frame_end,
  input  logic                vid_req,
  input  logic [ADDR_W-1:0]   vid_addr,
  output logic [DATA_W-1:0]   vid_rdata,
  output logic                vid_rvalid,
  input  logic                eng_req,
  input  logic                eng_we,
  input  logic [ADDR_W-1:0]   eng_addr,
  input  logic [DATA_W-1:0]   eng_wdata,
  output logic                eng_gnt,
  output logic [DATA_W-1:0]   eng_rdata,
  output logic                eng_rvalid,
  input  logic                gen_done,
  output logic                gen_start,
  input  logic                cfg_req,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [DATA_W-1:0]   cfg_wdata,
  output logic                cfg_gnt,
  output logic                disp_bank,
  gol_mem_scheduler_if.master mem
);

  gol_state_e        state_q, state_d;
  logic              disp_q, swap, swap_q, gen_start_q;
  logic              vid_ok, eng_ok, cfg_ok, freeze_w;
  logic              rd_issue, rd_pend_q;
  gol_owner_e        rd_owner, rd_own_q;
  logic [DATA_W-1:0] vid_hold_q, eng_hold_q;

`ifdef GOL_FREEZE_EN
  assign freeze_w = freeze;
`else
  assign freeze_w = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= START;
      disp_q      <= 1'b0;
      swap_q      <= 1'b0;
      gen_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      swap_q      <= swap;
      gen_start_q <= (state_q == START) | swap_q;
      if (swap) disp_q <= ~disp_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      START:   state_d = RUN;
      RUN:     if (gen_done) state_d = DONE;
      DONE:    if (frame_end) state_d = freeze_w ? IDLE : RUN;
      IDLE:    if (frame_end && !freeze_w) state_d = RUN;
      default: state_d = START;
    endcase
  end

  // START blocks every requester so nothing reaches memory while coming out of reset
  always_comb begin
    vid_ok = (state_q != START);
    eng_ok = (state_q == RUN);
    cfg_ok = (state_q == DONE) || (state_q == IDLE);
    swap   = frame_end && !freeze_w && ((state_q == DONE) || (state_q == IDLE));
  end

  gol_mem_prio #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_prio (
    .vid_ok    (vid_ok),
    .eng_ok    (eng_ok),
    .cfg_ok    (cfg_ok),
    .disp_bank (disp_q),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .eng_req   (eng_req),
    .eng_we    (eng_we),
    .eng_addr  (eng_addr),
    .eng_wdata (eng_wdata),
    .cfg_req   (cfg_req),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .eng_gnt   (eng_gnt),
    .cfg_gnt   (cfg_gnt),
    .mem_en    (mem.en),
    .mem_we    (mem.we),
    .mem_bank  (mem.bank),
    .mem_addr  (mem.addr),
    .mem_wdata (mem.wdata),
    .rd_issue  (rd_issue),
    .rd_owner  (rd_owner)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pend_q  <= 1'b0;
      rd_own_q   <= OWN_VID;
      vid_hold_q <= '0;
      eng_hold_q <= '0;
    end else begin
      rd_pend_q <= rd_issue;
      rd_own_q  <= rd_owner;
      if (vid_rvalid) vid_hold_q <= mem.rdata;
      if (eng_rvalid) eng_hold_q <= mem.rdata;
    end
  end

  assign vid_rvalid = rd_pend_q && (rd_own_q == OWN_VID);
  assign eng_rvalid = rd_pend_q && (rd_own_q == OWN_ENG);
  assign vid_rdata  = vid_rvalid ? mem.rdata : vid_hold_q;
  assign eng_rdata  = eng_rvalid ? mem.rdata : eng_hold_q;
  assign gen_start  = gen_start_q;
  assign disp_bank  = disp_q;

endmodule

// File: tb/tb_gol_mem_scheduler.sv
// tb/tb_gol_mem_scheduler.sv - directed vector bench for gol_mem_scheduler
module tb_gol_mem_scheduler;

  logic        clk;
  logic        reset;
  logic        frame_end, vid_req, eng_req, eng_we, gen_done, cfg_req;
  logic [8:0]  vid_addr, eng_addr, cfg_addr;
  logic [31:0] eng_wdata, cfg_wdata;
  logic [31:0] vid_rdata, eng_rdata;
  logic        vid_rvalid, eng_gnt, eng_rvalid, gen_start, cfg_gnt, disp_bank;
`ifdef GOL_FREEZE_EN
  logic        freeze;
`endif

  int n_chk;
  int n_err;

  gol_mem_scheduler_if #(.ADDR_W(9), .DATA_W(32)) mem_if ();

  gol_mem_scheduler #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef GOL_FREEZE_EN
    .freeze     (freeze),
`endif
    .frame_end  (frame_end),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_rdata  (vid_rdata),
    .vid_rvalid (vid_rvalid),
    .eng_req    (eng_req),
    .eng_we     (eng_we),
    .eng_addr   (eng_addr),
    .eng_wdata  (eng_wdata),
    .eng_gnt    (eng_gnt),
    .eng_rdata  (eng_rdata),
    .eng_rvalid (eng_rvalid),
    .gen_done   (gen_done),
    .gen_start  (gen_start),
    .cfg_req    (cfg_req),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_gnt    (cfg_gnt),
    .disp_bank  (disp_bank),
    .mem        (mem_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vid, eng, we, cfg;
    logic [8:0]  a_vid, a_eng, a_cfg;
    logic [31:0] wd_eng, wd_cfg;
    logic        x_en, x_we, x_bank;
    logic [8:0]  x_addr;
    logic [31:0] x_wdata;
    logic        x_eg, x_cg;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
`ifdef GOL_FREEZE_EN
    freeze = 1'b0;
`endif
    frame_end = 0; vid_req = 0; eng_req = 0; eng_we = 0; gen_done = 0; cfg_req = 0;
    vid_addr = 0; eng_addr = 0; cfg_addr = 0; eng_wdata = 0; cfg_wdata = 0;
    mem_if.rdata = 0;

    // arbitration vectors, applied in RUN with disp_bank = 0
    vecs[0] = '{0,0,0,0, 9'h000,9'h000,9'h000, 32'h0,32'h0,                 0,0,0, 9'h000, 32'h0,          0,0};
    vecs[1] = '{1,0,0,0, 9'h005,9'h000,9'h000, 32'h0,32'h0,                 1,0,0, 9'h005, 32'h0,          0,0};
    vecs[2] = '{1,1,0,0, 9'h010,9'h010,9'h000, 32'h0,32'h0,                 1,0,0, 9'h010, 32'h0,          0,0};
    vecs[3] = '{0,1,0,0, 9'h000,9'h010,9'h000, 32'h0,32'h0,                 1,0,0, 9'h010, 32'h0,          1,0};
    vecs[4] = '{0,1,1,0, 9'h000,9'h1FF,9'h000, 32'hA5A5A5A5,32'h0,          1,1,1, 9'h1FF, 32'hA5A5A5A5,   1,0};
    vecs[5] = '{0,0,0,1, 9'h000,9'h000,9'h033, 32'h0,32'h0C0FFEE0,          0,0,0, 9'h000, 32'h0,          0,0};
    vecs[6] = '{0,1,1,1, 9'h000,9'h0AA,9'h033, 32'h12345678,32'h0C0FFEE0,   1,1,1, 9'h0AA, 32'h12345678,   1,0};
    vecs[7] = '{1,1,1,1, 9'h100,9'h0AA,9'h033, 32'h12345678,32'h0C0FFEE0,   1,0,0, 9'h100, 32'h0,          0,0};

    reset = 1'b1;
    #1 reset = 1'b0;
    vid_req = 1; eng_req = 1; cfg_req = 1;
    nedge(); nedge();
    #1;
    chk("rst_mem_en", 32'(mem_if.en), 32'd0);
    chk("rst_eng_gnt", 32'(eng_gnt), 32'd0);
    chk("rst_cfg_gnt", 32'(cfg_gnt), 32'd0);
    chk("rst_gen_start", 32'(gen_start), 32'd0);
    chk("rst_disp_bank", 32'(disp_bank), 32'd0);
    chk("rst_vid_rvalid", 32'(vid_rvalid), 32'd0);
    vid_req = 0; eng_req = 0; cfg_req = 0;

    nedge(); reset = 1'b1;
    nedge(); #1;
    chk("start_gen_start_c1", 32'(gen_start), 32'd1);
    chk("start_disp_bank", 32'(disp_bank), 32'd0);
    nedge(); #1;
    chk("start_gen_start_c2", 32'(gen_start), 32'd0);
    nedge(); #1;
    chk("start_gen_start_c3", 32'(gen_start), 32'd0);

    for (int i = 0; i < 8; i++) begin
      nedge();
      vid_req = vecs[i].vid; eng_req = vecs[i].eng; eng_we = vecs[i].we; cfg_req = vecs[i].cfg;
      vid_addr = vecs[i].a_vid; eng_addr = vecs[i].a_eng; cfg_addr = vecs[i].a_cfg;
      eng_wdata = vecs[i].wd_eng; cfg_wdata = vecs[i].wd_cfg;
      #1;
      chk($sformatf("vec%0d_mem_en", i), 32'(mem_if.en), 32'(vecs[i].x_en));
      chk($sformatf("vec%0d_mem_we", i), 32'(mem_if.we), 32'(vecs[i].x_we));
      chk($sformatf("vec%0d_mem_bank", i), 32'(mem_if.bank), 32'(vecs[i].x_bank));
      chk($sformatf("vec%0d_mem_addr", i), 32'(mem_if.addr), 32'(vecs[i].x_addr));
      chk($sformatf("vec%0d_mem_wdata", i), mem_if.wdata, vecs[i].x_wdata);
      chk($sformatf("vec%0d_eng_gnt", i), 32'(eng_gnt), 32'(vecs[i].x_eg));
      chk($sformatf("vec%0d_cfg_gnt", i), 32'(cfg_gnt), 32'(vecs[i].x_cg));
    end

    // video beats engine; both reads return with 1-cycle latency
    nedge();
    vid_req = 1; vid_addr = 9'h010; eng_req = 1; eng_we = 0; eng_addr = 9'h010; cfg_req = 0;
    mem_if.rdata = 32'h0;
    #1;
    chk("rd_eng_gnt_blocked", 32'(eng_gnt), 32'd0);
    chk("rd_vid_bank", 32'(mem_if.bank), 32'd0);
    nedge();
    vid_req = 0; mem_if.rdata = 32'h11112222;
    #1;
    chk("rd_vid_rvalid", 32'(vid_rvalid), 32'd1);
    chk("rd_vid_rdata", vid_rdata, 32'h11112222);
    chk("rd_eng_gnt_next", 32'(eng_gnt), 32'd1);
    chk("rd_eng_rvalid_early", 32'(eng_rvalid), 32'd0);
    nedge();
    eng_req = 0; mem_if.rdata = 32'hDEADBEEF;
    #1;
    chk("rd_eng_rvalid", 32'(eng_rvalid), 32'd1);
    chk("rd_eng_rdata", eng_rdata, 32'hDEADBEEF);
    chk("rd_vid_rvalid_off", 32'(vid_rvalid), 32'd0);
    chk("rd_vid_rdata_hold", vid_rdata, 32'h11112222);
    nedge();
    mem_if.rdata = 32'h0;
    #1;
    chk("rd_eng_rvalid_off", 32'(eng_rvalid), 32'd0);
    chk("rd_eng_rdata_hold", eng_rdata, 32'hDEADBEEF);

    // engine write to the hidden bank, no read data returned
    nedge();
    eng_req = 1; eng_we = 1; eng_addr = 9'h1FF; eng_wdata = 32'hCAFEF00D;
    #1;
    chk("wr_mem_we", 32'(mem_if.we), 32'd1);
    chk("wr_mem_bank", 32'(mem_if.bank), 32'd1);
    chk("wr_mem_addr", 32'(mem_if.addr), 32'h1FF);
    chk("wr_mem_wdata", mem_if.wdata, 32'hCAFEF00D);
    nedge();
    eng_req = 0; eng_we = 0;
    #1;
    chk("wr_no_vid_rvalid", 32'(vid_rvalid), 32'd0);
    chk("wr_no_eng_rvalid", 32'(eng_rvalid), 32'd0);

    // frame_end while RUN is ignored
    nedge(); frame_end = 1;
    nedge(); frame_end = 0;
    #1;
    chk("run_fe_disp", 32'(disp_bank), 32'd0);
    nedge(); #1;
    chk("run_fe_disp2", 32'(disp_bank), 32'd0);
    chk("run_fe_gen_start", 32'(gen_start), 32'd0);

    // gen_done -> DONE: cfg allowed on hidden bank, engine held off
    nedge(); gen_done = 1;
    nedge(); gen_done = 0;
    cfg_req = 1; cfg_addr = 9'h033; cfg_wdata = 32'h0C0FFEE0;
    #1;
    chk("done_cfg_gnt", 32'(cfg_gnt), 32'd1);
    chk("done_cfg_we", 32'(mem_if.we), 32'd1);
    chk("done_cfg_bank", 32'(mem_if.bank), 32'd1);
    chk("done_cfg_addr", 32'(mem_if.addr), 32'h033);
    chk("done_cfg_wdata", mem_if.wdata, 32'h0C0FFEE0);
    nedge();
    cfg_req = 0; eng_req = 1; eng_we = 0; eng_addr = 9'h020;
    #1;
    chk("done_eng_gnt", 32'(eng_gnt), 32'd0);
    chk("done_mem_en", 32'(mem_if.en), 32'd0);
    nedge(); frame_end = 1;
    #1;
    chk("swap_disp_before", 32'(disp_bank), 32'd0);
    chk("swap_eng_gnt_before", 32'(eng_gnt), 32'd0);
    nedge(); frame_end = 0;
    #1;
    chk("swap_disp_after", 32'(disp_bank), 32'd1);
    chk("swap_gen_start_c1", 32'(gen_start), 32'd0);
    chk("swap_eng_gnt", 32'(eng_gnt), 32'd1);
    chk("swap_eng_bank", 32'(mem_if.bank), 32'd1);
    chk("swap_eng_addr", 32'(mem_if.addr), 32'h020);
    nedge(); eng_req = 0;
    #1;
    chk("swap_gen_start_c2", 32'(gen_start), 32'd1);
    nedge(); #1;
    chk("swap_gen_start_c3", 32'(gen_start), 32'd0);

    // reset with an engine read in flight
    nedge();
    eng_req = 1; eng_we = 0; eng_addr = 9'h040;
    #1;
    chk("inflight_eng_gnt", 32'(eng_gnt), 32'd1);
    chk("inflight_bank", 32'(mem_if.bank), 32'd1);
    nedge();
    eng_req = 0; mem_if.rdata = 32'h55AA55AA; reset = 1'b0;
    #1;
    chk("rst2_eng_rvalid", 32'(eng_rvalid), 32'd0);
    chk("rst2_eng_rdata", eng_rdata, 32'h0);
    chk("rst2_disp_bank", 32'(disp_bank), 32'd0);
    nedge(); mem_if.rdata = 32'h0;
    nedge(); reset = 1'b1;
    nedge(); #1;
    chk("rst2_gen_start_c1", 32'(gen_start), 32'd1);
    chk("rst2_disp_after", 32'(disp_bank), 32'd0);
    nedge(); #1;
    chk("rst2_gen_start_c2", 32'(gen_start), 32'd0);

    // gen_done and frame_end together: DONE now, swap only at the next frame_end
    nedge(); gen_done = 1; frame_end = 1;
    nedge(); gen_done = 0; frame_end = 0;
    cfg_req = 1; cfg_addr = 9'h011; cfg_wdata = 32'h00000077;
    #1;
    chk("both_disp_hold", 32'(disp_bank), 32'd0);
    chk("both_cfg_gnt", 32'(cfg_gnt), 32'd1);
    chk("both_cfg_bank", 32'(mem_if.bank), 32'd1);
    nedge(); #1;
    chk("both_gen_start", 32'(gen_start), 32'd0);
    chk("both_disp_hold2", 32'(disp_bank), 32'd0);
    cfg_req = 0;
    nedge(); frame_end = 1;
    nedge(); frame_end = 0;
    #1;
    chk("both_disp_swap", 32'(disp_bank), 32'd1);
    nedge(); #1;
    chk("both_gen_start_pulse", 32'(gen_start), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
